// File: rtl/fixed_point_narrow.sv
// Narrows Q(2I).(2F) accumulator values to Q(I).(F) with saturation, 2-stage pipe.
// Define NARROW_ROUND_EN for round-half-up; otherwise truncates toward -inf.
module fixed_point_narrow #(
  parameter int W  = 16,
  parameter int I  = 4,
  parameter int CW = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic           out_sat,
  output logic [CW-1:0]  sat_count,
  input  logic           sat_clear
);

  localparam int F  = W - I;
  localparam int RW = 2 * W + 1;
  localparam int QW = RW - F;

`ifdef NARROW_ROUND_EN
  localparam logic [RW-1:0] RND = {{(RW-1){1'b0}}, 1'b1} << (F - 1);
`else
  localparam logic [RW-1:0] RND = '0;
`endif

  localparam logic signed [QW-1:0] QMAX =
    {{(QW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [QW-1:0] QMIN =
    {{(QW-W+1){1'b1}}, {(W-1){1'b0}}};

  localparam logic [W-1:0] DMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] DMIN = {1'b1, {(W-1){1'b0}}};

  logic          adv1;
  logic          adv2;

  logic          s1_valid_q;
  logic          s1_valid_d;
  logic [RW-1:0] r_q;
  logic [RW-1:0] r_d;

  logic          out_valid_q;
  logic          out_valid_d;
  logic [W-1:0]  out_data_q;
  logic [W-1:0]  out_data_d;
  logic          out_sat_q;
  logic          out_sat_d;
  logic [CW-1:0] sat_count_q;
  logic [CW-1:0] sat_count_d;

  logic signed [QW-1:0] q;
  logic          sat_hi;
  logic          sat_lo;
  logic          unused_frac;

  // Upper slice of r equals r >>> F truncated to QW bits.
  assign q           = r_q[RW-1:F];
  assign unused_frac = ^r_q[F-1:0];
  assign sat_hi      = q > QMAX;
  assign sat_lo      = q < QMIN;

  assign adv2     = !out_valid_q || out_ready;
  assign adv1     = !s1_valid_q || adv2;
  assign in_ready = adv1;

  always_comb begin
    s1_valid_d = s1_valid_q;
    r_d        = r_q;
    if (adv1) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        r_d = {in_data[2*W-1], in_data} + RND;
      end
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    if (adv2) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        if (sat_hi) begin
          out_data_d = DMAX;
          out_sat_d  = 1'b1;
        end else if (sat_lo) begin
          out_data_d = DMIN;
          out_sat_d  = 1'b1;
        end else begin
          out_data_d = q[W-1:0];
          out_sat_d  = 1'b0;
        end
      end
    end
  end

  // Clear wins over a same-cycle increment.
  always_comb begin
    sat_count_d = sat_count_q;
    if (sat_clear) begin
      sat_count_d = '0;
    end else if (out_valid_q && out_ready && out_sat_q &&
                 (sat_count_q != {CW{1'b1}})) begin
      sat_count_d = sat_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q  <= 1'b0;
      r_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      sat_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      r_q         <= r_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      sat_count_q <= sat_count_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;
  assign sat_count = sat_count_q;

endmodule

// File: tb/tb_fixed_point_narrow.sv
// Randomized and directed bench for fixed_point_narrow.
// Reference model narrows with plain integer arithmetic.
module tb_fixed_point_narrow;

  localparam int W  = 16;
  localparam int I  = 4;
  localparam int F  = W - I;
  localparam int CW = 16;

`ifdef NARROW_ROUND_EN
  localparam longint RND = longint'(1) << (F - 1);
  localparam bit     RE  = 1'b1;
`else
  localparam longint RND = 0;
  localparam bit     RE  = 1'b0;
`endif

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [2*W-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic           out_sat;
  logic [CW-1:0]  sat_count;
  logic           sat_clear;

  fixed_point_narrow #(.W(W), .I(I), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .sat_count (sat_count),
    .sat_clear (sat_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns {sat, data}.
  function automatic logic [W:0] golden(input logic [2*W-1:0] d);
    longint v;
    longint lim;
    logic [W-1:0] od;
    lim = longint'(1) << (W - 1);
    v = longint'($signed(d)) + RND;
    v = v >>> F;
    if (v > lim - 1) return {1'b1, 1'b0, {(W-1){1'b1}}};
    if (v < -lim) return {1'b1, 1'b1, {(W-1){1'b0}}};
    od = v[W-1:0];
    return {1'b0, od};
  endfunction

  logic [W:0] expq[$];
  int         n_push = 0;
  longint     mcnt = 0;
  logic       hold_q = 1'b0;
  logic [W:0] hold_v;
  logic       sb_ev;
  logic [W:0] sb_e;

  always @(negedge clk) begin
    if (!rst) begin
      expq.delete();
      mcnt   = 0;
      hold_q = 1'b0;
    end else begin
      sb_ev = 1'b0;
      check("sat_count", sat_count, mcnt);
      if (hold_q)
        check("hold", {out_valid, out_sat, out_data}, {1'b1, hold_v});
      if (out_valid && out_ready) begin
        check("expect_pending", expq.size() > 0, 1'b1);
        if (expq.size() > 0) begin
          sb_e = expq.pop_front();
          check("sb_data", out_data, sb_e[W-1:0]);
          check("sb_sat", out_sat, sb_e[W]);
          sb_ev = sb_e[W];
        end
      end
      hold_q = out_valid && !out_ready;
      hold_v = {out_sat, out_data};
      if (in_valid && in_ready) begin
        expq.push_back(golden(in_data));
        n_push++;
      end
      if (sat_clear) mcnt = 0;
      else if (sb_ev && mcnt < (longint'(1) << CW) - 1) mcnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dir(input string tag, input logic [2*W-1:0] d,
                     input logic [W-1:0] ed, input logic es);
    in_valid = 1'b1;
    in_data  = d;
    check({tag, "_rdy"}, in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    in_data  = $urandom;
    check({tag, "_lat1"}, out_valid, 1'b0);
    step();
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_data"}, out_data, ed);
    check({tag, "_sat"}, out_sat, es);
  endtask

  function automatic logic [2*W-1:0] pick();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0: return r;
      1: return {{4{r[27]}}, r[27:0]};
      2: return 32'h07FF_F000 + {19'd0, r[12:0]};
      default: return 32'hF800_0000 - {19'd0, r[12:0]};
    endcase
  endfunction

  int cyc;
  int base;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    sat_clear = 1'b0;
    #2 rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 16'h0000);
    check("rst_out_sat", out_sat, 1'b0);
    check("rst_sat_count", sat_count, 16'h0000);
    step();
    step();
    rst = 1'b1;
    check("rdy_after_rst", in_ready, 1'b1);

    dir("t1_one", 32'h0100_0000, 16'h1000, 1'b0);
    dir("t2_half", 32'h0000_0800, RE ? 16'h0001 : 16'h0000, 1'b0);
    dir("t2_mhalf", 32'hFFFF_F800, RE ? 16'h0000 : 16'hFFFF, 1'b0);
    dir("t3_pos", 32'h0800_0000, 16'h7FFF, 1'b1);
    dir("t3_neg", 32'hF000_0000, 16'h8000, 1'b1);
    dir("t3_min", 32'hF800_0000, 16'h8000, 1'b0);
    dir("t3_rnd", 32'h07FF_F800, 16'h7FFF, RE);
    step();
    check("t3_count", sat_count, RE ? 16'd3 : 16'd2);

    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h0000_1000;
    step();
    in_data = 32'h0000_2000;
    step();
    in_data = 32'h0000_3000;
    check("t4_rdy", in_ready, 1'b0);
    check("t4_hold", out_data, 16'h0001);
    check("t4_valid", out_valid, 1'b1);
    repeat (3) begin
      step();
      check("t4_rdy", in_ready, 1'b0);
      check("t4_hold", out_data, 16'h0001);
    end
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("t4_o2v", out_valid, 1'b1);
    check("t4_o2", out_data, 16'h0002);
    step();
    check("t4_o3v", out_valid, 1'b1);
    check("t4_o3", out_data, 16'h0003);
    step();
    check("t4_empty", out_valid, 1'b0);

    base = n_push;
    cyc  = 0;
    while (n_push < base + 100 && cyc < 3000) begin
      out_ready = $urandom_range(0, 3) != 0;
      in_valid  = $urandom_range(0, 3) != 0;
      in_data   = pick();
      sat_clear = $urandom_range(0, 40) == 0;
      step();
      cyc++;
    end
    in_valid  = 1'b0;
    sat_clear = 1'b0;
    check("t5_accept_timeout", cyc < 3000, 1'b1);
    cyc = 0;
    while (expq.size() != 0 && cyc < 300) begin
      out_ready = $urandom_range(0, 1);
      step();
      cyc++;
    end
    check("t5_drain", expq.size(), 0);
    out_ready = 1'b1;

    dir("t6_pre", 32'h0800_0000, 16'h7FFF, 1'b1);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h0800_0000;
    step();
    in_data = 32'hF000_0000;
    step();
    in_valid = 1'b0;
    check("t6_inflight", out_valid, 1'b1);
    rst = 1'b0;
    #1;
    check("t6_rst_valid", out_valid, 1'b0);
    check("t6_rst_count", sat_count, 16'h0000);
    step();
    rst = 1'b1;
    out_ready = 1'b1;
    repeat (4) begin
      step();
      check("t6_stale", out_valid, 1'b0);
    end

    dir("t6_a", 32'h0800_0000, 16'h7FFF, 1'b1);
    step();
    check("t6_cnt1", sat_count, 16'd1);
    dir("t6_b", 32'hF000_0000, 16'h8000, 1'b1);
    sat_clear = 1'b1;
    step();
    sat_clear = 1'b0;
    check("t6_clear", sat_count, 16'd0);
    step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
